// File: rtl/nqbus_pkg.sv
// nqbus_pkg: shared types and defaults for the two-master memory bus arbiter.
// Holds the arbiter state encoding, owner index constants and bus width defaults.
package nqbus_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int HOLD_MAX_DEF = 4;

    // Owner indices: m0 = CPU port, m1 = debug/loader DMA port
    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    // One-hot {m1,m0} grant vector for an owner index
    function automatic logic [1:0] owner_grant(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection used when the bus is idle.
// Build option ARB_ROUND_ROBIN_EN: a tie goes to the master that did not own
// the bus last; without it m0 (CPU) always wins a tie.
module arb_pick
    import nqbus_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_pick
);

`ifdef ARB_ROUND_ROBIN_EN
    // Tie: alternate away from the last owner; single requester always wins
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1)
            o_pick = ~i_last_owner;
        else if (i_req1)
            o_pick = OWN_M1;
        else
            o_pick = OWN_M0;
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_owner;

    // Fixed priority: CPU first, DMA only when the CPU is quiet
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_pick  = i_req0 ? OWN_M0 : OWN_M1;
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 16-bit memory bus between m0 (CPU) and m1 (DMA).
// The owner's cycle is forwarded combinationally; the non-owner is stalled via
// needWait. HOLD_MAX bounds how many back-to-back completions an owner keeps
// while the other master waits.
// Build option ARB_ROUND_ROBIN_EN (see arb_pick) changes the idle tie-break only.
module mem_bus_arbiter
    import nqbus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_re_i,
    input  logic              m0_we_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_needWait_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_re_i,
    input  logic              m1_we_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_needWait_o,
    output logic [ADDR_W-1:0] t_addr_o,
    output logic              t_re_o,
    output logic              t_we_o,
    inout  wire  [DATA_W-1:0] t_data_io,
    input  logic              t_needWait_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam int HC_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

    arb_state_t        r_state;
    logic [1:0]        r_grant;
    logic              r_last_owner;
    logic [HC_W-1:0]   r_hold_cnt;

    logic              w_req0;
    logic              w_req1;
    logic              w_owning;
    logic              w_own_idx;
    logic [ADDR_W-1:0] w_o_addr;
    logic              w_o_re;
    logic              w_o_we;
    logic [DATA_W-1:0] w_o_wdata;
    logic              w_o_req;
    logic              w_x_req;
    logic              w_rd_done;
    logic              w_stay;
    logic              w_pick_valid;
    logic              w_pick;

    assign w_req0    = m0_re_i | m0_we_i;
    assign w_req1    = m1_re_i | m1_we_i;
    assign w_owning  = (r_state != ARB_IDLE);
    assign w_own_idx = (r_state == ARB_OWN1);

    arb_pick u_pick (
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_pick       (w_pick)
    );

    // Select the current owner's request fields and the other master's request
    always_comb begin
        w_o_addr  = w_own_idx ? m1_addr_i : m0_addr_i;
        w_o_re    = w_own_idx ? m1_re_i   : m0_re_i;
        w_o_we    = w_own_idx ? m1_we_i   : m0_we_i;
        w_o_wdata = w_own_idx ? m1_data_i : m0_data_i;
        w_o_req   = w_own_idx ? w_req1    : w_req0;
        w_x_req   = w_own_idx ? w_req0    : w_req1;
    end

    // Target side mirrors the owner; re+we together is forwarded as a write only
    always_comb begin
        t_addr_o = w_owning ? w_o_addr : '0;
        t_we_o   = w_owning & w_o_we;
        t_re_o   = w_owning & w_o_re & ~w_o_we;
    end

    assign t_data_io = t_we_o ? w_o_wdata : {DATA_W{1'bz}};
    assign w_rd_done = t_re_o & ~t_needWait_i;

    // Master side: owner sees the target stall, non-owner stalls, idle masters never stall
    always_comb begin
        m0_needWait_o = w_req0 & ((r_state == ARB_OWN0) ? t_needWait_i : 1'b1);
        m1_needWait_o = w_req1 & ((r_state == ARB_OWN1) ? t_needWait_i : 1'b1);
        m0_data_o     = ((r_state == ARB_OWN0) && w_rd_done) ? t_data_io : '0;
        m1_data_o     = ((r_state == ARB_OWN1) && w_rd_done) ? t_data_io : '0;
    end

    // Keep the bus after a completion unless the waiting master has been held off long enough
    assign w_stay = ~w_x_req | ((int'(r_hold_cnt) + 1) < HOLD_MAX);

    assign grant_o = r_grant;
    assign busy_o  = w_owning;

    // Ownership FSM: idle arbitration, completion accounting, abort and hand-over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_grant      <= 2'b00;
            r_hold_cnt   <= '0;
            r_last_owner <= OWN_M1;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state      <= w_pick ? ARB_OWN1 : ARB_OWN0;
                        r_grant      <= owner_grant(w_pick);
                        r_last_owner <= w_pick;
                        r_hold_cnt   <= '0;
                    end
                end
                ARB_OWN0, ARB_OWN1: begin
                    if (!w_o_req) begin
                        // Owner abandoned its cycle: release the bus
                        r_state    <= ARB_IDLE;
                        r_grant    <= 2'b00;
                        r_hold_cnt <= '0;
                    end else if (!t_needWait_i) begin
                        if (w_stay) begin
                            r_hold_cnt <= w_x_req ? r_hold_cnt + 1'b1 : '0;
                        end else if (w_x_req) begin
                            r_state      <= w_own_idx ? ARB_OWN0 : ARB_OWN1;
                            r_grant      <= owner_grant(~w_own_idx);
                            r_last_owner <= ~w_own_idx;
                            r_hold_cnt   <= '0;
                        end else begin
                            r_state    <= ARB_IDLE;
                            r_grant    <= 2'b00;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state    <= ARB_IDLE;
                    r_grant    <= 2'b00;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random two-master traffic,
// checked every cycle against a transaction-level ownership model.
module tb_mem_bus_arbiter;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr [2];
    logic        re   [2];
    logic        we   [2];
    logic [15:0] wd   [2];
    logic [15:0] m0_data_o, m1_data_o;
    logic        m0_needWait_o, m1_needWait_o;
    logic [15:0] t_addr_o;
    logic        t_re_o, t_we_o;
    wire  [15:0] t_data_io;
    logic        tnw;
    logic [15:0] tgt_rdata;
    logic [1:0]  grant_o;
    logic        busy_o;

    assign t_data_io = t_we_o ? 16'hzzzz : tgt_rdata;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(addr[0]), .m0_re_i(re[0]), .m0_we_i(we[0]), .m0_data_i(wd[0]),
        .m0_data_o(m0_data_o), .m0_needWait_o(m0_needWait_o),
        .m1_addr_i(addr[1]), .m1_re_i(re[1]), .m1_we_i(we[1]), .m1_data_i(wd[1]),
        .m1_data_o(m1_data_o), .m1_needWait_o(m1_needWait_o),
        .t_addr_o(t_addr_o), .t_re_o(t_re_o), .t_we_o(t_we_o), .t_data_io(t_data_io),
        .t_needWait_i(tnw), .grant_o(grant_o), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the bus (-1 = nobody), completions in a row while the
    // other master waits, who owned last, and who completed at the last edge.
    int m_own    = -1;
    int m_streak = 0;
    int m_last   = 1;
    bit comp [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit req(input int i);
        return re[i] | we[i];
    endfunction

    task automatic model_reset();
        m_own = -1; m_streak = 0; m_last = 1;
        comp[0] = 0; comp[1] = 0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle
    task automatic model_update();
        int o, x, w;
        comp[0] = 0; comp[1] = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_own < 0) begin
            if (req(0) || req(1)) begin
                if (req(0) && req(1)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = 1 - m_last;
`else
                    w = 0;
`endif
                end else begin
                    w = req(0) ? 0 : 1;
                end
                m_own = w; m_last = w; m_streak = 0;
            end
        end else begin
            o = m_own; x = 1 - o;
            if (!req(o)) begin
                m_own = -1; m_streak = 0;
            end else if (!tnw) begin
                comp[o] = 1;
                m_streak = req(x) ? m_streak + 1 : 0;
                if (req(x) && m_streak >= HOLD) begin
                    m_own = x; m_last = x; m_streak = 0;
                end
            end
        end
    endtask

    // Compare every DUT output against what the model says this cycle must show
    task automatic settle();
        logic [1:0]  e_grant;
        logic        e_tre, e_twe;
        logic [15:0] e_taddr, e_bus;
        logic        e_nw [2];
        logic [15:0] e_do [2];
        #2;
        e_grant = 2'b00; e_tre = 0; e_twe = 0; e_taddr = 16'h0; e_bus = tgt_rdata;
        if (m_own >= 0) begin
            e_grant = (m_own == 0) ? 2'b01 : 2'b10;
            e_twe   = we[m_own];
            e_tre   = re[m_own] & ~we[m_own];
            e_taddr = addr[m_own];
            if (e_twe) e_bus = wd[m_own];
        end
        for (int i = 0; i < 2; i++) begin
            e_nw[i] = req(i) && ((m_own == i) ? tnw : 1'b1);
            e_do[i] = (m_own == i && re[i] && !we[i] && !tnw) ? tgt_rdata : 16'h0;
        end
        chk("grant",    {30'd0, grant_o}, {30'd0, e_grant});
        chk("busy",     {31'd0, busy_o}, {31'd0, (m_own >= 0) ? 1'b1 : 1'b0});
        chk("t_re",     {31'd0, t_re_o}, {31'd0, e_tre});
        chk("t_we",     {31'd0, t_we_o}, {31'd0, e_twe});
        chk("t_addr",   {16'd0, t_addr_o}, {16'd0, e_taddr});
        chk("t_data",   {16'd0, t_data_io}, {16'd0, e_bus});
        chk("m0_wait",  {31'd0, m0_needWait_o}, {31'd0, e_nw[0]});
        chk("m1_wait",  {31'd0, m1_needWait_o}, {31'd0, e_nw[1]});
        chk("m0_rdata", {16'd0, m0_data_o}, {16'd0, e_do[0]});
        chk("m1_rdata", {16'd0, m1_data_o}, {16'd0, e_do[1]});
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        edge_step();
    endtask

    task automatic set_m(input int i, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        re[i] = r; we[i] = w; addr[i] = a; wd[i] = d;
    endtask

    task automatic new_req(input int i);
        int k;
        k = $urandom_range(0, 5);
        set_m(i, (k <= 2 || k == 5), (k >= 3), 16'($urandom), 16'($urandom));
    endtask

    int cnt;
    bit seen;

    initial begin
        rst_n = 1'b0; tnw = 1'b0; tgt_rdata = 16'h0;
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        model_reset();

        // Reset state, then reset in the middle of an owned m0 read
        tick();
        set_m(0, 1, 0, 16'h0004, 16'h0);
        settle();
        chk("rst_wait_eq_req", {31'd0, m0_needWait_o}, 32'd1);
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        edge_step();
        rst_n = 1'b1;
        tnw = 1'b1;
        tick();
        settle();
        chk("t1_grant", {30'd0, grant_o}, 32'd1);
        chk("t1_re", {31'd0, t_re_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_async_re", {31'd0, t_re_o}, 32'd0);
        chk("t1_async_grant", {30'd0, grant_o}, 32'd0);
        edge_step();
        rst_n = 1'b1;
        tick();
        settle();
        chk("t1_regrant", {30'd0, grant_o}, 32'd1);
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        tick();

        // m0 read with two target wait cycles
        set_m(0, 1, 0, 16'h0010, 16'h0);
        tnw = 1'b1; tgt_rdata = 16'hBEEF;
        settle();
        chk("t2_wait0", {31'd0, m0_needWait_o}, 32'd1);
        edge_step();
        settle();
        chk("t2_grant", {30'd0, grant_o}, 32'd1);
        chk("t2_addr", {16'd0, t_addr_o}, 32'h0010);
        chk("t2_wait1", {31'd0, m0_needWait_o}, 32'd1);
        edge_step();
        settle();
        chk("t2_wait2", {31'd0, m0_needWait_o}, 32'd1);
        edge_step();
        tnw = 1'b0;
        settle();
        chk("t2_done_wait", {31'd0, m0_needWait_o}, 32'd0);
        chk("t2_rdata", {16'd0, m0_data_o}, 32'hBEEF);
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        tick();

        // Simultaneous requests from idle, straight after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tnw = 1'b1;
        set_m(0, 1, 0, 16'h0020, 16'h0);
        set_m(1, 1, 0, 16'h0030, 16'h0);
        tick();
        settle();
        chk("t3_tie1", {30'd0, grant_o}, 32'd1);
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        tick();
        set_m(0, 1, 0, 16'h0020, 16'h0);
        set_m(1, 1, 0, 16'h0030, 16'h0);
        tick();
        settle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_tie2", {30'd0, grant_o}, 32'd2);
`else
        chk("t3_tie2", {30'd0, grant_o}, 32'd1);
`endif
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        tick();

        // m0 streams zero-wait reads while m1 waits: HOLD completions, then hand-over
        tnw = 1'b0;
        set_m(0, 1, 0, 16'h0100, 16'h0);
        tick();
        set_m(1, 1, 0, 16'h0200, 16'h0);
        cnt = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            settle();
            if (grant_o == 2'b10) seen = 1;
            else begin
                if (grant_o == 2'b01 && !m0_needWait_o) cnt++;
                edge_step();
            end
        end
        chk("t4_completions", cnt, HOLD);
        chk("t4_handover", {30'd0, grant_o}, 32'd2);
        set_m(0, 0, 0, 16'h0, 16'h0);
        set_m(1, 0, 0, 16'h0, 16'h0);
        edge_step();

        // m1 write, then m0 re+we forwarded as a write
        set_m(1, 0, 1, 16'h8000, 16'h1234);
        tick();
        settle();
        chk("t5_we", {31'd0, t_we_o}, 32'd1);
        chk("t5_re", {31'd0, t_re_o}, 32'd0);
        chk("t5_addr", {16'd0, t_addr_o}, 32'h8000);
        chk("t5_data", {16'd0, t_data_io}, 32'h1234);
        edge_step();
        set_m(1, 0, 0, 16'h0, 16'h0);
        set_m(0, 1, 1, 16'h0042, 16'h5555);
        tick();
        tick();
        settle();
        chk("t5_rw_re", {31'd0, t_re_o}, 32'd0);
        chk("t5_rw_we", {31'd0, t_we_o}, 32'd1);
        chk("t5_rw_data", {16'd0, t_data_io}, 32'h5555);
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        tick();

        // Owner aborts during a target stall
        tnw = 1'b1;
        set_m(0, 1, 0, 16'h0077, 16'h0);
        tick();
        settle();
        chk("t6_re_on", {31'd0, t_re_o}, 32'd1);
        edge_step();
        set_m(0, 0, 0, 16'h0, 16'h0);
        settle();
        chk("t6_re_drop", {31'd0, t_re_o}, 32'd0);
        edge_step();
        settle();
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_grant", {30'd0, grant_o}, 32'd0);
        edge_step();

        // Random traffic from both masters against a randomly stalling target
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req(i)) begin
                    if ($urandom_range(0, 99) < 40) new_req(i);
                end else if (comp[i]) begin
                    if ($urandom_range(0, 99) < 70) new_req(i);
                    else set_m(i, 0, 0, 16'h0, 16'h0);
                end else if ($urandom_range(0, 99) < 3) begin
                    set_m(i, 0, 0, 16'h0, 16'h0);
                end
            end
            tnw = ($urandom_range(0, 3) == 0);
            tgt_rdata = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
